video_sprite_engine: RTL and testbench

//  Parametrised scanline sprite renderer for the tile-map video path. It replaces the per-pixel

---
 rtl/video_sprite_engine.sv | 227 ++++++++++++++++++++++
 tb/tb_video_sprite_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_sprite_engine.sv
// Scanline sprite renderer: scan/select sprites for the next line, fetch their rows into a back line buffer, stream the front buffer.
// Latency: pix_index/pix_palette one cycle after x/active; sprite memory data one cycle after spr_ren.
// No backpressure: a new line_start always wins, aborting an unfinished render (overrun). Optional: SPRITE_ENGINE_HFLIP_EN.
module video_sprite_engine #(
    parameter int NUM_SPRITES  = 16,
    parameter int MAX_PER_LINE = 8,
    parameter int LINE_W       = 320,
    parameter int PIX_W        = 2,
    parameter int SPR_AW       = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iomem_valid,
    input  logic [3:0]        iomem_wstrb,
    input  logic [31:0]       iomem_addr,
    input  logic [31:0]       iomem_wdata,
    input  logic              line_start,
    input  logic [7:0]        next_y,
    input  logic [8:0]        x,
    input  logic              active,
    output logic [SPR_AW-1:0] spr_raddr,
    output logic              spr_ren,
    input  logic [PIX_W-1:0]  spr_rdata,
    output logic [PIX_W-1:0]  pix_index,
    output logic [3:0]        pix_palette,
    output logic              overflow,
    output logic              overrun
);
    localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int EW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
    localparam int CW = $clog2(MAX_PER_LINE + 1);
    localparam int BW = 4 + PIX_W;
    localparam logic [9:0] LINE_W10 = 10'(LINE_W);

    typedef enum logic [1:0] {IDLE, SCAN, FETCH, DRAIN} state_t;
    state_t state_q, state_d;

    logic [31:0]   cfg [NUM_SPRITES];
    logic [7:0]    ny;
    logic [IW-1:0] scan_idx;
    logic [CW-1:0] lcnt;
    logic [EW-1:0] ent;
    logic [3:0]    col;
    logic [8:0]    lx   [MAX_PER_LINE];
    logic [3:0]    lrow [MAX_PER_LINE];
    logic [6:0]    lpat [MAX_PER_LINE];
    logic [3:0]    lpal [MAX_PER_LINE];
    logic          d_vld;
    logic [8:0]    d_tgt;
    logic [3:0]    d_pal;
    logic          front_sel;
    logic [LINE_W-1:0] vld0, vld1;
    logic [BW-1:0] dat0 [LINE_W];
    logic [BW-1:0] dat1 [LINE_W];

    // Config bus decode
    logic       cfg_we;
    logic [4:0] wr_idx;
    assign cfg_we = iomem_valid && (iomem_addr[23:20] == 4'h6);
    assign wr_idx = iomem_addr[6:2];

    // Scan evaluation of the current sprite against the latched line
    logic [31:0] cur;
    logic [7:0]  dy;
    logic        hit, list_full, push, scan_last;
    assign cur       = cfg[scan_idx];
    assign dy        = ny - cur[16:9];
    assign hit       = (state_q == SCAN) && cur[31] && (dy[7:4] == 4'd0);
    assign list_full = (lcnt >= CW'(MAX_PER_LINE));
    assign push      = hit && !list_full && !line_start;
    assign scan_last = (scan_idx == IW'(NUM_SPRITES - 1));

    // Fetch address generation for the current list entry
    logic       ent_last;
    logic [3:0] col_eff;
    assign ent_last = ((CW'(ent) + CW'(1)) == lcnt);
`ifdef SPRITE_ENGINE_HFLIP_EN
    logic lhf [MAX_PER_LINE];
    assign col_eff = lhf[ent] ? ~col : col;
`else
    assign col_eff = col;
`endif
    assign spr_raddr = spr_ren ? SPR_AW'({lpat[ent], lrow[ent], col_eff}) : '0;

    logic unused_bits;
`ifdef SPRITE_ENGINE_HFLIP_EN
    assign unused_bits = ^{iomem_addr[31:24], iomem_addr[19:7], iomem_addr[1:0], cur[29:28]};
`else
    assign unused_bits = ^{iomem_addr[31:24], iomem_addr[19:7], iomem_addr[1:0], cur[30:28]};
`endif

    // Back-buffer write: opaque, on-screen, and not already owned by a lower entry
    logic back_vld, wr_en;
    assign back_vld = front_sel ? vld0[d_tgt] : vld1[d_tgt];
    assign wr_en    = d_vld && (spr_rdata != '0) && ({1'b0, d_tgt} < LINE_W10) && !back_vld;

    // Front-buffer read at the current pixel
    logic          rd_en, frd_vld;
    logic [BW-1:0] frd_dat;
    assign rd_en   = active && ({1'b0, x} < LINE_W10);
    assign frd_vld = front_sel ? vld1[x] : vld0[x];
    assign frd_dat = front_sel ? dat1[x] : dat0[x];

    // Sprite config registers with byte-lane writes
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) cfg[i] <= '0;
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_SPRITES; i++)
                if (wr_idx == 5'(i))
                    for (int b = 0; b < 4; b++)
                        if (iomem_wstrb[b]) cfg[i][8*b +: 8] <= iomem_wdata[8*b +: 8];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state and read strobe; line_start restarts from any state
    always_comb begin
        state_d = state_q;
        spr_ren = 1'b0;
        case (state_q)
            IDLE:  state_d = IDLE;
            SCAN:  if (scan_last) state_d = (lcnt != '0 || hit) ? FETCH : IDLE;
            FETCH: begin
                spr_ren = 1'b1;
                if (col == 4'd15 && ent_last) state_d = DRAIN;
            end
            DRAIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (line_start) state_d = SCAN;
    end

    // Scan/fetch counters, latched line number and the read-data pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            ny <= '0; scan_idx <= '0; lcnt <= '0; ent <= '0; col <= '0;
            d_vld <= 1'b0; d_tgt <= '0; d_pal <= '0;
        end else begin
            d_vld <= spr_ren && !line_start;
            d_tgt <= lx[ent] + 9'(col);
            d_pal <= lpal[ent];
            if (line_start) begin
                ny <= next_y; scan_idx <= '0; lcnt <= '0; ent <= '0; col <= '0;
            end else if (state_q == SCAN) begin
                if (!scan_last) scan_idx <= scan_idx + 1'b1;
                if (push) lcnt <= lcnt + 1'b1;
            end else if (state_q == FETCH) begin
                col <= col + 1'b1;
                if (col == 4'd15) ent <= ent + 1'b1;
            end
        end
    end

    // Select list entries for the next line
    always_ff @(posedge clk) begin
        if (push) begin
            lx[lcnt[EW-1:0]]   <= cur[8:0];
            lrow[lcnt[EW-1:0]] <= dy[3:0];
            lpat[lcnt[EW-1:0]] <= cur[23:17];
            lpal[lcnt[EW-1:0]] <= cur[27:24];
`ifdef SPRITE_ENGINE_HFLIP_EN
            lhf[lcnt[EW-1:0]]  <= cur[30];
`endif
        end
    end

    // Sticky status; a config write clears, a same-cycle event re-sets
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (cfg_we) begin
                overflow <= 1'b0;
                overrun  <= 1'b0;
            end
            if (hit && list_full && !line_start) overflow <= 1'b1;
            if (line_start && (state_q == SCAN || state_q == FETCH)) overrun <= 1'b1;
        end
    end

    // Buffer valid bits: render sets in back, display clears in front
    always_ff @(posedge clk) begin
        if (reset) begin
            vld0 <= '0;
            vld1 <= '0;
            front_sel <= 1'b0;
        end else begin
            if (line_start) front_sel <= ~front_sel;
            if (rd_en) begin
                if (front_sel) vld1[x] <= 1'b0;
                else           vld0[x] <= 1'b0;
            end
            if (wr_en) begin
                if (front_sel) vld0[d_tgt] <= 1'b1;
                else           vld1[d_tgt] <= 1'b1;
            end
        end
    end

    // Buffer pixel/palette storage
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (front_sel) dat0[d_tgt] <= {d_pal, spr_rdata};
            else           dat1[d_tgt] <= {d_pal, spr_rdata};
        end
    end

    // Registered pixel output; blank outside the visible region
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_index   <= '0;
            pix_palette <= '0;
        end else if (rd_en && frd_vld) begin
            {pix_palette, pix_index} <= frd_dat;
        end else begin
            pix_index   <= '0;
            pix_palette <= '0;
        end
    end
endmodule

// File: tb/tb_video_sprite_engine.sv
// Bench for video_sprite_engine: per-pixel reference model feeds a scoreboard of expected display pixels.
// Each line_start shifts the model's previous line into the expected-display slot.
// Sprite memory modelled as a 1-cycle-latency ROM of fixed patterns.
module tb_video_sprite_engine;
    localparam int NS = 16, MAXL = 8, LW = 320;
`ifdef SPRITE_ENGINE_HFLIP_EN
    localparam bit HF = 1'b1;
`else
    localparam bit HF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, iomem_valid, line_start, active;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr, iomem_wdata;
    logic [7:0]  next_y;
    logic [8:0]  x;
    logic [14:0] spr_raddr;
    logic        spr_ren;
    logic [1:0]  spr_rdata, pix_index;
    logic [3:0]  pix_palette;
    logic        overflow, overrun;

    video_sprite_engine dut (
        .clk(clk), .reset(reset), .iomem_valid(iomem_valid), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .line_start(line_start),
        .next_y(next_y), .x(x), .active(active), .spr_raddr(spr_raddr), .spr_ren(spr_ren),
        .spr_rdata(spr_rdata), .pix_index(pix_index), .pix_palette(pix_palette),
        .overflow(overflow), .overrun(overrun)
    );

    logic [1:0]  smem [0:32767];
    logic [31:0] shadow [NS];
    logic [5:0]  cur_exp [LW];
    logic [5:0]  nxt_exp [LW];
    logic [5:0]  cap [LW];
    logic [5:0]  sbq [$];
    int checks = 0, errors = 0;
    bit ovf_exp, ovr_exp, partial;
    int part_nz;
    logic       samp;
    logic [8:0] samp_x;

    always @(posedge clk) spr_rdata <= spr_ren ? smem[spr_raddr] : 2'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input int sx, input int sy, input int pat, input int pal,
                                       input bit hf, input bit en);
        return {en, hf, 2'b00, 4'(pal), 7'(pat), 8'(sy), 9'(sx)};
    endfunction

    task automatic cfg_write(input int idx, input logic [31:0] d, input logic [3:0] be);
        iomem_valid = 1'b1; iomem_wstrb = be;
        iomem_addr = 32'h0060_0000 | (32'(idx) << 2); iomem_wdata = d;
        tick;
        iomem_valid = 1'b0; iomem_wstrb = 4'h0;
        for (int b = 0; b < 4; b++) if (be[b]) shadow[idx][8*b +: 8] = d[8*b +: 8];
        ovf_exp = 1'b0; ovr_exp = 1'b0;
    endtask

    // Reference: for each pixel, the lowest-index selected sprite with an opaque pixel there
    task automatic build_line(input logic [7:0] ny);
        int hits = 0;
        int sel [$];
        logic [7:0] dy;
        logic [8:0] d;
        logic [3:0] c;
        logic [1:0] p;
        bit found;
        for (int i = 0; i < NS; i++) begin
            dy = ny - shadow[i][16:9];
            if (shadow[i][31] && dy < 8'd16) begin
                hits++;
                if (hits <= MAXL) sel.push_back(i);
            end
        end
        if (hits > MAXL) ovf_exp = 1'b1;
        for (int px = 0; px < LW; px++) begin
            nxt_exp[px] = 6'd0;
            found = 1'b0;
            foreach (sel[k]) begin
                d = 9'(px) - shadow[sel[k]][8:0];
                dy = ny - shadow[sel[k]][16:9];
                if (!found && d < 9'd16) begin
                    c = (HF && shadow[sel[k]][30]) ? 4'(15 - d) : d[3:0];
                    p = smem[{shadow[sel[k]][23:17], dy[3:0], c}];
                    if (p != 2'd0) begin
                        nxt_exp[px] = {shadow[sel[k]][27:24], p};
                        found = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic line_pulse(input logic [7:0] ny);
        line_start = 1'b1; next_y = ny;
        tick;
        line_start = 1'b0;
        for (int i = 0; i < LW; i++) cur_exp[i] = nxt_exp[i];
        build_line(ny);
    endtask

    task automatic display;
        for (int i = 0; i < LW; i++) begin
            active = 1'b1; x = 9'(i);
            sbq.push_back(cur_exp[i]);
            tick;
        end
        active = 1'b0; x = 9'd0;
        tick; tick;
        chk("blank_out", {pix_palette, pix_index}, 6'd0);
    endtask

    task automatic do_line(input logic [7:0] ny);
        line_pulse(ny);
        repeat (4) tick;
        display;
        chk("overflow", overflow, ovf_exp);
        chk("overrun", overrun, ovr_exp);
    endtask

    always @(posedge clk) begin
        samp   <= active;
        samp_x <= x;
    end

    // Scoreboard compare of the registered pixel outputs
    always @(negedge clk) begin
        logic [5:0] e, got;
        if (samp) begin
            e = (sbq.size() > 0) ? sbq.pop_front() : 6'bx;
            got = {pix_palette, pix_index};
            if (samp_x < 9'(LW)) cap[samp_x] = got;
            if (partial) begin
                if (got != 6'd0) part_nz++;
            end else begin
                chk($sformatf("pix x=%0d", samp_x), got, e);
            end
        end
    end

    initial begin
        logic [14:0] av;
        for (int a = 0; a < 32768; a++) begin
            av = 15'(a);
            case (av[14:8])
                7'd1:    smem[a] = 2'd1;
                7'd2:    smem[a] = av[0] ? 2'd0 : 2'd2;
                7'd3:    smem[a] = av[1:0];
                7'd4:    smem[a] = (av[7:4] == 4'd8) ? 2'd3 : 2'd1;
                default: smem[a] = 2'd0;
            endcase
        end
        for (int i = 0; i < NS; i++) shadow[i] = '0;
        for (int i = 0; i < LW; i++) begin nxt_exp[i] = '0; cap[i] = '0; end
        ovf_exp = 0; ovr_exp = 0; partial = 0; part_nz = 0;
        reset = 1; iomem_valid = 0; iomem_wstrb = 0; iomem_addr = 0; iomem_wdata = 0;
        line_start = 0; next_y = 0; x = 0; active = 0;
        repeat (4) tick;
        chk("rst_pix", {pix_palette, pix_index}, 6'd0);
        chk("rst_ren", spr_ren, 1'b0);
        chk("rst_raddr", spr_raddr, 15'd0);
        chk("rst_flags", {overflow, overrun}, 2'b00);
        reset = 0;
        tick;

        // Single solid sprite
        cfg_write(0, mk(10, 20, 1, 5, 0, 1), 4'hF);
        do_line(20); do_line(200);
        chk("t1_x9", cap[9], 6'd0);
        chk("t1_x10", cap[10], {4'd5, 2'd1});
        chk("t1_x25", cap[25], {4'd5, 2'd1});
        chk("t1_x26", cap[26], 6'd0);

        // Overlap: sprite 0 wins where opaque, sprite 1 shows through holes
        cfg_write(0, mk(10, 20, 2, 5, 0, 1), 4'hF);
        cfg_write(1, mk(10, 20, 1, 9, 0, 1), 4'hF);
        do_line(20); do_line(200);
        chk("t2_x10", cap[10], {4'd5, 2'd2});
        chk("t2_x11", cap[11], {4'd9, 2'd1});

        // Nine sprites on one line: ninth dropped, overflow sticky
        for (int i = 0; i < 9; i++) cfg_write(i, mk(i * 20, 50, 1, i, 0, 1), 4'hF);
        do_line(50); do_line(0);
        chk("t3_spr7", cap[140], {4'd7, 2'd1});
        chk("t3_spr8", cap[160], 6'd0);
        chk("t3_ovf_set", overflow, 1'b1);
        cfg_write(8, 32'h0, 4'b1000);
        chk("t3_ovf_clr", overflow, 1'b0);

        // Render cut short by an early line_start
        line_pulse(50);
        repeat (20) tick;
        line_pulse(0);
        ovr_exp = 1'b1;
        chk("t4_overrun", overrun, 1'b1);
        partial = 1; part_nz = 0;
        display;
        partial = 0;
        chk("t4_partial", (part_nz > 0 && part_nz < 16), 1'b1);
        do_line(50); do_line(0);
        chk("t4_recover", cap[0], {4'd0, 2'd1});

        // Right-edge clipping, x wrap mod 512, y wrap mod 256
        for (int i = 0; i < 8; i++) cfg_write(i, 32'h0, 4'hF);
        cfg_write(0, mk(312, 20, 1, 3, 0, 1), 4'hF);
        do_line(20); do_line(200);
        chk("t5_x312", cap[312], {4'd3, 2'd1});
        chk("t5_x319", cap[319], {4'd3, 2'd1});
        chk("t5_x0", cap[0], 6'd0);
        chk("t5_x7", cap[7], 6'd0);
        cfg_write(0, 32'h0, 4'hF);
        cfg_write(1, mk(100, 250, 4, 6, 0, 1), 4'hF);
        cfg_write(2, mk(508, 250, 1, 4, 0, 1), 4'hF);
        do_line(2); do_line(200);
        chk("t5_row8", cap[100], {4'd6, 2'd3});
        chk("t5_xwrap0", cap[0], {4'd4, 2'd1});
        chk("t5_xwrap11", cap[11], {4'd4, 2'd1});
        chk("t5_xwrap12", cap[12], 6'd0);

        // Horizontal flip on a ramp pattern
        cfg_write(1, 32'h0, 4'hF);
        cfg_write(2, 32'h0, 4'hF);
        cfg_write(0, mk(0, 20, 3, 2, 1, 1), 4'hF);
        do_line(20); do_line(200);
`ifdef SPRITE_ENGINE_HFLIP_EN
        chk("t6_x0", cap[0], {4'd2, 2'd3});
        chk("t6_x1", cap[1], {4'd2, 2'd2});
        chk("t6_x15", cap[15], 6'd0);
`else
        chk("t6_x0", cap[0], 6'd0);
        chk("t6_x1", cap[1], {4'd2, 2'd1});
        chk("t6_x15", cap[15], {4'd2, 2'd3});
`endif
        chk("sb_left", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
